// File: rtl/tt_pkg.sv
// Shared types and helpers for the truth-table sweeper.
package tt_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // A HOLD of 1 still needs a one-bit counter, hence the floor at 1.
    function automatic int cnt_width(input int n);
        int w;
        w = $clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/tt_sweeper_hold_timer.sv
// Modulo-HOLD counter; tc marks the last cycle of each hold window.
import tt_pkg::*;

module hold_timer #(
    parameter int HOLD = 100
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam int W = cnt_width(HOLD);
    localparam logic [W-1:0] LAST = W'(HOLD - 1);

    logic [W-1:0] cnt;

    assign tc = en && (cnt == LAST);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (en) begin
            if (cnt == LAST) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + W'(1);
            end
        end
    end

endmodule

// File: rtl/tt_sweeper.sv
// Sweeps every input vector of a small combinational DUT and checks y_in
// against an expected truth table, keeping the error count and first failure.
import tt_pkg::*;

module tt_sweeper #(
    parameter int                   N_IN   = 3,
    parameter int                   HOLD   = 100,
    parameter logic [(1<<N_IN)-1:0] EXPECT = 8'b1110_1000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            y_in,
    output logic [N_IN-1:0] vec,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [N_IN:0]   err_cnt,
    output logic [N_IN-1:0] first_fail,
    output logic            first_fail_vld,
    output logic [1:0]      fsm_state
);

    localparam int NVEC = 1 << N_IN;
    localparam logic [N_IN-1:0] VEC_LAST = N_IN'(NVEC - 1);

    localparam logic [1:0] S_IDLE = IDLE;
    localparam logic [1:0] S_RUN  = RUN;
    localparam logic [1:0] S_DONE = DONE;

    logic [1:0] state;
    logic       tc;
    logic       mismatch;

    hold_timer #(
        .HOLD (HOLD)
    ) u_hold_timer (
        .clk (clk),
        .rst (rst),
        .clr (state != S_RUN),
        .en  (state == S_RUN),
        .tc  (tc)
    );

    // start is a one-cycle request accepted only when not busy; done is a
    // level that stays up until the next accepted start or rst.
    assign busy      = (state == S_RUN);
    assign done      = (state == S_DONE);
    assign pass      = done && (err_cnt == '0);
    assign fsm_state = state;
    assign mismatch  = (y_in != EXPECT[vec]);

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= S_IDLE;
            vec            <= '0;
            err_cnt        <= '0;
            first_fail     <= '0;
            first_fail_vld <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state          <= S_RUN;
                        vec            <= '0;
                        err_cnt        <= '0;
                        first_fail     <= '0;
                        first_fail_vld <= 1'b0;
                    end
                end
                S_RUN: begin
                    if (tc) begin
                        if (mismatch) begin
                            err_cnt <= err_cnt + (N_IN+1)'(1);
                            if (!first_fail_vld) begin
                                first_fail     <= vec;
                                first_fail_vld <= 1'b1;
                            end
                        end
                        if (vec != VEC_LAST) begin
                            vec <= vec + N_IN'(1);
                        end else begin
                            state <= S_DONE;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tt_sweeper.sv
// Directed bench for tt_sweeper: a 3-input/HOLD=4 majority sweep and a
// 4-input/HOLD=1 parity sweep, checked against queued expectations.
module tb_tt_sweeper;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst    = 1'b1;
    logic start3 = 1'b0;
    logic start4 = 1'b0;
    int   mode   = 0;

    logic [2:0] vec3;
    logic       y3, busy3, done3, pass3, ffv3;
    logic [3:0] err3;
    logic [2:0] ff3;
    logic [1:0] st3;

    logic [3:0] vec4;
    logic       y4, busy4, done4, pass4, ffv4;
    logic [4:0] err4;
    logic [3:0] ff4;
    logic [1:0] st4;

    int checks = 0;
    int errors = 0;

    logic [2:0] exp_q[$];
    logic [8:0] exp_res_q[$];
    logic [3:0] exp4_q[$];

    tt_sweeper #(.N_IN(3), .HOLD(4), .EXPECT(8'b1110_1000)) u_dut3 (
        .clk(clk), .rst(rst), .start(start3), .y_in(y3), .vec(vec3),
        .busy(busy3), .done(done3), .pass(pass3), .err_cnt(err3),
        .first_fail(ff3), .first_fail_vld(ffv3), .fsm_state(st3)
    );

    tt_sweeper #(.N_IN(4), .HOLD(1), .EXPECT(16'h6996)) u_dut4 (
        .clk(clk), .rst(rst), .start(start4), .y_in(y4), .vec(vec4),
        .busy(busy4), .done(done4), .pass(pass4), .err_cnt(err4),
        .first_fail(ff4), .first_fail_vld(ffv4), .fsm_state(st4)
    );

    function automatic logic maj(input logic [2:0] v);
        return (v[2] & v[1]) | (v[2] & v[0]) | (v[1] & v[0]);
    endfunction

    // mode 0: good DUT, 1: stuck-at-0, 2: wrong only at 5, 3: fully inverted
    function automatic logic y_model(input int m, input logic [2:0] v);
        case (m)
            1:       return 1'b0;
            2:       return (v == 3'd5) ? ~maj(v) : maj(v);
            3:       return ~maj(v);
            default: return maj(v);
        endcase
    endfunction

    always_comb y3 = y_model(mode, vec3);
    assign y4 = ^vec4;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sweep3(input int m, input int poke_at, input int abort_at);
        int         e;
        logic       ffv;
        logic [2:0] ff;
        logic [8:0] r;
        logic [2:0] ev;
        e = 0; ffv = 1'b0; ff = 3'd0;
        mode = m;
        for (int v = 0; v < 8; v++) begin
            if (y_model(m, 3'(v)) != maj(3'(v))) begin
                e++;
                if (!ffv) ff = 3'(v);
                ffv = 1'b1;
            end
            for (int h = 0; h < 4; h++) exp_q.push_back(3'(v));
        end
        exp_res_q.push_back({(e == 0), ffv, ff, e[3:0]});

        start3 = 1'b1;
        tick();
        start3 = 1'b0;
        for (int c = 0; c < 32; c++) begin
            ev = exp_q.pop_front();
            check("vec3", 32'(vec3), 32'(ev));
            check("busy3", 32'(busy3), 32'd1);
            check("done3_low", 32'(done3), 32'd0);
            check("pass3_low", 32'(pass3), 32'd0);
            if (c == 0) begin
                check("err3_cleared", 32'(err3), 32'd0);
                check("ffv3_cleared", 32'(ffv3), 32'd0);
            end
            if (c == abort_at) begin
                check("err3_before_rst", 32'(err3), 32'd3);
                rst    = 1'b1;
                start3 = 1'b1;
                tick();
                rst    = 1'b0;
                start3 = 1'b0;
                check("rst_vec3", 32'(vec3), 32'd0);
                check("rst_busy3", 32'(busy3), 32'd0);
                check("rst_done3", 32'(done3), 32'd0);
                check("rst_err3", 32'(err3), 32'd0);
                check("rst_ffv3", 32'(ffv3), 32'd0);
                check("rst_state3", 32'(st3), 32'd0);
                exp_q.delete();
                void'(exp_res_q.pop_back());
                return;
            end
            if (c == poke_at) start3 = 1'b1;
            tick();
            start3 = 1'b0;
        end
        r = exp_res_q.pop_front();
        check("done3", 32'(done3), 32'd1);
        check("busy3_end", 32'(busy3), 32'd0);
        check("state3_done", 32'(st3), 32'd2);
        check("vec3_end", 32'(vec3), 32'd7);
        check("err3", 32'(err3), 32'(r[3:0]));
        check("ffv3", 32'(ffv3), 32'(r[7]));
        if (r[7]) check("ff3", 32'(ff3), 32'(r[6:4]));
        check("pass3", 32'(pass3), 32'(r[8]));
    endtask

    initial begin
        rst = 1'b1;
        tick();
        tick();
        check("rst_vec3", 32'(vec3), 32'd0);
        check("rst_busy3", 32'(busy3), 32'd0);
        check("rst_done3", 32'(done3), 32'd0);
        check("rst_pass3", 32'(pass3), 32'd0);
        check("rst_err3", 32'(err3), 32'd0);
        check("rst_ff3", 32'(ff3), 32'd0);
        check("rst_ffv3", 32'(ffv3), 32'd0);
        check("rst_vec4", 32'(vec4), 32'd0);
        check("rst_done4", 32'(done4), 32'd0);
        rst = 1'b0;
        tick();
        check("idle_busy3", 32'(busy3), 32'd0);

        sweep3(0, -1, -1);
        repeat (3) tick();
        check("done3_held", 32'(done3), 32'd1);
        check("vec3_held", 32'(vec3), 32'd7);

        sweep3(1, -1, -1);
        sweep3(2, -1, -1);
        sweep3(0, -1, -1);
        sweep3(0, 8, -1);
        sweep3(3, -1, 12);
        tick();
        check("idle_after_rst", 32'(st3), 32'd0);
        sweep3(0, -1, -1);

        for (int v = 0; v < 16; v++) exp4_q.push_back(4'(v));
        start4 = 1'b1;
        tick();
        start4 = 1'b0;
        for (int c = 0; c < 16; c++) begin
            check("vec4", 32'(vec4), 32'(exp4_q.pop_front()));
            check("busy4", 32'(busy4), 32'd1);
            tick();
        end
        check("done4", 32'(done4), 32'd1);
        check("pass4", 32'(pass4), 32'd1);
        check("err4", 32'(err4), 32'd0);
        check("ffv4", 32'(ffv4), 32'd0);
        check("vec4_end", 32'(vec4), 32'd15);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/tt_sweeper.md
Name: tt_sweeper

Overview:
- Synthesizable, self-checking truth-table sweeper for small combinational lab blocks.
- Drives every input combination of an N-input DUT in ascending binary order and holds each vector for a programmable number of cycles.
- Samples the DUT output and compares it against a parameterised expected truth table, reporting the error count and the first failing vector.
- Sits beside the DUT on the board or in simulation, replacing hand-written per-vector stimulus.

Parameters:
N_IN, 3, number of DUT inputs (1..8); sweep length is 2**N_IN vectors.
HOLD, 100, clock cycles each vector is held (>=1).
EXPECT, 8'b1110_1000, expected output table, width 2**N_IN; bit i is the expected y for vec==i (default = 3-input majority).

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  synchronous, active-high reset.
start  in  1  single-cycle request to begin a sweep.
y_in  in  1  DUT output under test.
vec  out  N_IN  DUT input vector; vec[N_IN-1] is the MSB input (a for a 3-input DUT).
busy  out  1  high while a sweep is in progress.
done  out  1  high after sweep completion, until the next start or rst.
pass  out  1  valid when done=1; high iff err_cnt==0.
err_cnt  out  N_IN+1  number of mismatching vectors in the last sweep.
first_fail  out  N_IN  lowest vec that mismatched; valid when first_fail_vld=1.
first_fail_vld  out  1  at least one mismatch has been recorded in this sweep.

Behaviour:
- One clock: clk. Reset is synchronous and active-high: rst, sampled on the rising edge of clk.
- Reset values: every output is 0; FSM is in IDLE; hold counter is 0.
- FSM states:
  - IDLE: busy=0, done=0. start=1 -> RUN, with vec=0, hold_cnt=0, err_cnt=0, first_fail_vld=0 and busy=1, all from the next edge.
  - RUN: hold_cnt increments each cycle. When hold_cnt==HOLD-1 (the sample cycle), y_in is compared to EXPECT[vec].
    - On mismatch: err_cnt increments. If first_fail_vld==0, first_fail<=vec and first_fail_vld<=1.
    - If vec != 2**N_IN-1: vec increments and hold_cnt resets to 0.
    - Else -> DONE.
  - DONE: busy=0, done=1, pass=(err_cnt==0). vec holds its last value. start=1 -> RUN, with the same clearing as from IDLE.
- Timing:
  - Vector i is driven for exactly HOLD cycles.
  - y_in is sampled on the last cycle of each hold window, giving the DUT HOLD-1 cycles to settle.
  - The first vec=0 cycle is the edge after start.
  - done rises exactly 2**N_IN*HOLD cycles after that edge.
- HOLD=1: the sample occurs on every cycle and vec advances each cycle.
- start during RUN is ignored; the sweep is not restarted.
- rst mid-sweep overrides everything: all outputs return to 0 and the FSM goes to IDLE on that edge. rst has priority over start in the same cycle.
- err_cnt is N_IN+1 bits wide, so it holds 2**N_IN without overflow. No saturation logic is needed.
- pass is 0 whenever done=0.
- hold_cnt width is max(1, $clog2(HOLD)).
- EXPECT indexing uses vec directly; bit 0 corresponds to all-zero inputs.

Decomposition:
- Package tt_pkg:
  - state enum {IDLE, RUN, DONE}.
  - Localparam helper NVEC = 2**N_IN (computed in the module from N_IN).
  - Function for the counter width: max(1, clog2).
- One sub-module, hold_timer:
  - Parameterised modulo-HOLD counter with clear and enable inputs and a terminal-count output (tc).
  - The sweeper uses tc as the sample/advance strobe.
- The vector counter, comparator and error bookkeeping stay in tt_sweeper.

Test Plan:
1. N_IN=3, HOLD=4, y_in = behavioural majority(vec); pulse start -> vec steps 0..7, 4 cycles each; done=1 after 32 cycles; err_cnt=0, pass=1, first_fail_vld=0.
2. Same parameters, y_in tied 0 -> err_cnt=4, pass=0, first_fail=3'b011, first_fail_vld=1.
3. Majority model with the output inverted only at vec=5 -> err_cnt=1, first_fail=5; restart with start -> counters cleared, and a fault-free second sweep gives pass=1.
4. Pulse start again at vec=2 mid-sweep -> no restart; vec continues to 3; total sweep length stays 32 cycles.
5. Assert rst while vec=3 -> next edge: vec=0, busy=0, done=0, err_cnt=0; a following start begins again at vec=0.
6. N_IN=4, HOLD=1, EXPECT=16'h6996 (parity), y_in = ^vec -> vec advances every cycle; done after 16 cycles; pass=1.
